// File: rtl/bounded_universal_counter.sv
// Bounded up/down/bounce counter with programmable limits, step size and wrap/saturate policy.
// Sums and compares are one bit wider than the count, so a step never aliases modulo 2^WIDTH.
module bounded_universal_counter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo_lim,
  input  logic [WIDTH-1:0]  hi_lim,
  input  logic              sat,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              tc,
  output logic              err
);

  localparam int unsigned XW = WIDTH + 1;

  localparam logic [1:0] ModeHold   = 2'b00;
  localparam logic [1:0] ModeUp     = 2'b01;
  localparam logic [1:0] ModeDown   = 2'b10;
  localparam logic [1:0] ModeBounce = 2'b11;

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;

  logic [XW-1:0]    cnt_x, lo_x, hi_x, step_x, up_sum, lo_plus, dn_diff;
  logic             lim_err;
  logic             active;
  logic             moving_up;
  logic             wrapped;
  logic [WIDTH-1:0] target;

  assign cnt_x   = {1'b0, count_q};
  assign lo_x    = {1'b0, lo_lim};
  assign hi_x    = {1'b0, hi_lim};
  assign step_x  = XW'(step);
  assign up_sum  = cnt_x + step_x;
  assign lo_plus = lo_x + step_x;
  assign dn_diff = cnt_x - step_x;

  assign lim_err = (lo_lim > hi_lim);
  assign active  = !load && !lim_err && enable && (mode != ModeHold) && (step != '0);
  assign err_d   = lim_err;

  always_comb begin
    count_d   = count_q;
    dir_d     = dir_q;
    moving_up = 1'b1;
    wrapped   = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (active) begin
      case (mode)
        ModeUp: begin
          moving_up = 1'b1;
          if (up_sum <= hi_x && cnt_x >= lo_x) begin
            count_d = up_sum[WIDTH-1:0];
          end else if (sat) begin
            count_d = hi_lim;
          end else begin
            count_d = lo_lim;
            wrapped = (up_sum > hi_x);
          end
        end
        ModeDown: begin
          moving_up = 1'b0;
          if (cnt_x >= lo_plus && cnt_x <= hi_x) begin
            count_d = dn_diff[WIDTH-1:0];
          end else if (sat) begin
            count_d = lo_lim;
          end else begin
            count_d = hi_lim;
            wrapped = (cnt_x < lo_plus);
          end
        end
        ModeBounce: begin
          // Out-of-range counts clamp to the violated limit and turn back into range.
          if (cnt_x < lo_x) begin
            moving_up = 1'b1;
            count_d   = lo_lim;
            dir_d     = 1'b1;
          end else if (cnt_x > hi_x) begin
            moving_up = 1'b0;
            count_d   = hi_lim;
            dir_d     = 1'b0;
          end else if (dir_q) begin
            moving_up = 1'b1;
            if (up_sum >= hi_x) begin
              count_d = hi_lim;
              dir_d   = 1'b0;
            end else begin
              count_d = up_sum[WIDTH-1:0];
            end
          end else begin
            moving_up = 1'b0;
            if (cnt_x <= lo_plus) begin
              count_d = lo_lim;
              dir_d   = 1'b1;
            end else begin
              count_d = dn_diff[WIDTH-1:0];
            end
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  always_comb begin
    target = moving_up ? hi_lim : lo_lim;
    tc_d   = active && !wrapped && (count_d == target) && (count_d != count_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign tc    = tc_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bounded_universal_counter.sv
// Directed bench for bounded_universal_counter: wrap, saturate, bounce, hold, error and overflow.
module tb_bounded_universal_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] step;
  logic [7:0] lo_lim;
  logic [7:0] hi_lim;
  logic       sat;
  logic [7:0] count;
  logic       dir;
  logic       tc;
  logic       err;

  int checks = 0;
  int errors = 0;

  int sd_cnt [5] = '{5, 3, 2, 2, 2};
  int sd_tc  [5] = '{0, 0, 1, 0, 0};
  int bn_cnt [9] = '{13, 16, 19, 20, 17, 14, 11, 10, 13};
  int bn_tc  [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
  int bn_dir [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};

  bounded_universal_counter #(
    .WIDTH (8),
    .STEP_W(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .mode    (mode),
    .load    (load),
    .load_val(load_val),
    .step    (step),
    .lo_lim  (lo_lim),
    .hi_lim  (hi_lim),
    .sat     (sat),
    .count   (count),
    .dir     (dir),
    .tc      (tc),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int d, input int t, input int e);
    chk({tag, ".count"}, 32'(count), c);
    chk({tag, ".dir"},   32'(dir),   d);
    chk({tag, ".tc"},    32'(tc),    t);
    chk({tag, ".err"},   32'(err),   e);
  endtask

  initial begin
    // Reset must win over a simultaneous load.
    rst_n = 1'b0; load = 1'b1; load_val = 8'h55;
    enable = 1'b1; mode = 2'b01; step = 4'd1;
    lo_lim = 8'd0; hi_lim = 8'd9; sat = 1'b0;
    tick();
    tick();
    chk_all("reset", 0, 1, 0, 0);
    rst_n = 1'b1; load = 1'b0;

    // Mod-10 wrap
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mod10.count", 32'(count), (i + 1) % 10);
      chk("mod10.tc", 32'(tc), ((i + 1) % 10 == 9) ? 1 : 0);
    end

    // Saturating down
    lo_lim = 8'd2; hi_lim = 8'd50; step = 4'd2; mode = 2'b10; sat = 1'b1;
    load = 1'b1; load_val = 8'd7;
    tick();
    chk("satdn.load", 32'(count), 7);
    chk("satdn.load_tc", 32'(tc), 0);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("satdn.count", 32'(count), sd_cnt[i]);
      chk("satdn.tc", 32'(tc), sd_tc[i]);
    end

    // Bounce with step 3
    lo_lim = 8'd10; hi_lim = 8'd20; step = 4'd3; mode = 2'b11;
    load = 1'b1; load_val = 8'd10;
    tick();
    chk("bounce.load", 32'(count), 10);
    chk("bounce.load_dir", 32'(dir), 1);
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("bounce.count", 32'(count), bn_cnt[i]);
      chk("bounce.tc", 32'(tc), bn_tc[i]);
      chk("bounce.dir", 32'(dir), bn_dir[i]);
    end

    // Hold conditions: enable low, mode 00, step 0
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("hold.en", 13, 1, 0, 0);
    end
    enable = 1'b1; mode = 2'b00;
    tick();
    chk_all("hold.mode", 13, 1, 0, 0);
    mode = 2'b11; step = 4'd0;
    tick();
    chk_all("hold.step0", 13, 1, 0, 0);

    // Limit error: count frozen, load still honoured
    step = 4'd3; lo_lim = 8'd30; hi_lim = 8'd20;
    tick();
    chk_all("err.set", 13, 1, 0, 1);
    load = 1'b1; load_val = 8'd99;
    tick();
    chk_all("err.load", 99, 1, 0, 1);
    load = 1'b0;
    tick();
    chk_all("err.hold", 99, 1, 0, 1);

    // Wide-sum overflow: 254+15 exceeds 255 and wraps to lo, not to 13
    lo_lim = 8'd0; hi_lim = 8'd255; load = 1'b1; load_val = 8'd254;
    tick();
    chk_all("ovf.load", 254, 1, 0, 0);
    load = 1'b0; step = 4'd15; mode = 2'b01; sat = 1'b0;
    tick();
    chk_all("ovf.wrap", 0, 1, 0, 0);

    // Saturating up at top of range, tc only once
    load = 1'b1; load_val = 8'd250;
    tick();
    load = 1'b0; sat = 1'b1;
    tick();
    chk_all("satup.hit", 255, 1, 1, 0);
    tick();
    chk_all("satup.sit", 255, 1, 0, 0);

    // Mid-run reset with a same-cycle load
    rst_n = 1'b0; load = 1'b1; load_val = 8'd77;
    tick();
    chk_all("midreset", 0, 1, 0, 0);
    rst_n = 1'b1; load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
